// File: rtl/branch_repair_ctrl.sv
// Branch misprediction repair: accepts one amend request, issues the fetch
// redirect, then restores GHR/RAS pointer and trains the predictor for one cycle.
module branch_repair_ctrl #(
    parameter int          GHR_W     = 8,
    parameter int          RAS_PTR_W = 3,
    parameter logic [15:0] CNT_SAT   = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 amd_flush_i,
    input  logic [31:0]          amd_erroVAddr_i,
    input  logic [31:0]          amd_corrDest_i,
    input  logic                 amd_corrTake_i,
    input  logic [GHR_W-1:0]     amd_ckptGhr_i,
    input  logic [RAS_PTR_W-1:0] amd_ckptRasPtr_i,
    input  logic                 amd_isCall_i,
    input  logic                 amd_isRet_i,
    output logic                 amd_ready_o,
    input  logic                 exc_flush_i,
    output logic                 rdr_valid_o,
    output logic [31:0]          rdr_pc_o,
    input  logic                 rdr_ready_i,
    output logic                 rst_valid_o,
    output logic [GHR_W-1:0]     rst_ghr_o,
    output logic [RAS_PTR_W-1:0] rst_rasPtr_o,
    output logic                 upd_valid_o,
    output logic [31:0]          upd_pc_o,
    output logic                 upd_take_o,
    output logic [GHR_W-1:0]     upd_ghr_o,
    output logic [15:0]          mis_cnt_o,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REDIR   = 2'd1,
        RESTORE = 2'd2
    } state_t;

    state_t               state;
    logic [31:0]          erro_vaddr_q;
    logic                 corr_take_q;
    logic [GHR_W-1:0]     ckpt_ghr_q;
    logic [31:0]          rdr_pc_q;
    logic [GHR_W-1:0]     rst_ghr_q;
    logic [RAS_PTR_W-1:0] rst_ras_q;
    logic [15:0]          mis_cnt;

    logic                 accept;
    logic                 in_redir;
    logic                 in_restore;
    logic [31:0]          rdr_pc_next;
    logic [RAS_PTR_W-1:0] ras_next;

    // Handshakes: an amend request transfers on the edge where amd_flush_i and
    // amd_ready_o are both 1 (exception absent); the redirect transfers on the
    // edge where rdr_valid_o and rdr_ready_i are both 1, with rdr_pc_o held
    // constant until then. An exception kills every valid in the same cycle.
    assign amd_ready_o = rst && !exc_flush_i && (state == IDLE);
    assign accept      = amd_flush_i && amd_ready_o;
    assign in_redir    = rst && !exc_flush_i && (state == REDIR);
    assign in_restore  = rst && !exc_flush_i && (state == RESTORE);

    // Not-taken redirect skips the already-fetched delay slot.
    assign rdr_pc_next = amd_corrTake_i ? amd_corrDest_i : amd_erroVAddr_i + 32'd8;

    always_comb begin
        ras_next = amd_ckptRasPtr_i;
        if (amd_isCall_i)
            ras_next = amd_ckptRasPtr_i + RAS_PTR_W'(1);
        else if (amd_isRet_i)
            ras_next = amd_ckptRasPtr_i - RAS_PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            erro_vaddr_q <= '0;
            corr_take_q  <= 1'b0;
            ckpt_ghr_q   <= '0;
            rdr_pc_q     <= '0;
            rst_ghr_q    <= '0;
            rst_ras_q    <= '0;
            mis_cnt      <= '0;
        end else begin
            if (accept && (mis_cnt != CNT_SAT))
                mis_cnt <= mis_cnt + 16'd1;

            if (exc_flush_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            erro_vaddr_q <= amd_erroVAddr_i;
                            corr_take_q  <= amd_corrTake_i;
                            ckpt_ghr_q   <= amd_ckptGhr_i;
                            rdr_pc_q     <= rdr_pc_next;
                            rst_ghr_q    <= {amd_ckptGhr_i[GHR_W-2:0], amd_corrTake_i};
                            rst_ras_q    <= ras_next;
                            state        <= REDIR;
                        end
                    end
                    REDIR: begin
                        if (rdr_ready_i)
                            state <= RESTORE;
                    end
                    RESTORE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign rdr_valid_o  = in_redir;
    assign rdr_pc_o     = in_redir ? rdr_pc_q : '0;
    assign rst_valid_o  = in_restore;
    assign rst_ghr_o    = in_restore ? rst_ghr_q : '0;
    assign rst_rasPtr_o = in_restore ? rst_ras_q : '0;
    assign upd_valid_o  = in_restore;
    assign upd_pc_o     = in_restore ? erro_vaddr_q : '0;
    assign upd_take_o   = in_restore && corr_take_q;
    assign upd_ghr_o    = in_restore ? ckpt_ghr_q : '0;
    assign mis_cnt_o    = mis_cnt;
    assign dbg_state    = state;

endmodule

// File: doc/branch_repair_ctrl.md
BRANCH_REPAIR_CTRL -- requirements
Module: branch_repair_ctrl

Interface
REQ-001 Parameters SHALL be: GHR_W, 8, global history width; RAS_PTR_W, 3, return-stack pointer width.
REQ-002 Clock and reset SHALL be: clk input 1 clock; rst input 1 reset. Reset is synchronous and active-low.
REQ-003 Amend-request inputs SHALL be:
- amd_flush_i, input, 1, flush request.
- amd_erroVAddr_i, input, 32, PC of the mispredicted branch.
- amd_corrDest_i, input, 32, correct target.
- amd_corrTake_i, input, 1, correct direction.
- amd_ckptGhr_i, input, GHR_W, GHR checkpoint.
- amd_ckptRasPtr_i, input, RAS_PTR_W, RAS pointer checkpoint.
- amd_isCall_i, input, 1, branch is a call.
- amd_isRet_i, input, 1, branch is a return.
REQ-004 amd_ready_o SHALL be an output, 1 bit, meaning the request can be accepted this cycle.
REQ-005 Exception input SHALL be: exc_flush_i, input, 1, CP0 exception flush.
REQ-006 Redirect port SHALL be:
- rdr_valid_o, output, 1, redirect request.
- rdr_pc_o, output, 32, redirect PC.
- rdr_ready_i, input, 1, fetch accepts the redirect.
REQ-007 Restore port SHALL be:
- rst_valid_o, output, 1, restore strobe.
- rst_ghr_o, output, GHR_W, restored GHR.
- rst_rasPtr_o, output, RAS_PTR_W, restored RAS pointer.
REQ-008 Update port SHALL be:
- upd_valid_o, output, 1, predictor training strobe.
- upd_pc_o, output, 32, branch PC.
- upd_take_o, output, 1, trained direction.
- upd_ghr_o, output, GHR_W, index history.
REQ-009 mis_cnt_o SHALL be an output, 16 bits, wide count of accepted repairs.

Function
REQ-010 Accept rule: a request SHALL be accepted in a cycle with amd_flush_i && amd_ready_o && !exc_flush_i.
- On accept, all amd_* fields are latched.
- The FSM moves IDLE->REDIR.
REQ-011 The FSM SHALL have exactly three states: IDLE, REDIR and RESTORE.
REQ-012 amd_ready_o SHALL be 1 only in IDLE, and combinationally 0 whenever exc_flush_i=1.
REQ-013 In REDIR, the block SHALL drive rdr_valid_o=1.
- rdr_pc_o = corrTake ? corrDest : erroVAddr+8, because the delay slot is already fetched.
- The +8 is modulo 2^32.
REQ-014 rdr_valid_o and rdr_pc_o SHALL stay stable until rdr_ready_i=1.
- The handshake completes in the cycle where both are 1.
- The FSM then moves to RESTORE.
REQ-015 In RESTORE, the block SHALL assert rst_valid_o and upd_valid_o for exactly 1 cycle, then return to IDLE.
REQ-016 Restore values SHALL be:
- rst_ghr_o = {ckptGhr[GHR_W-2:0], corrTake}.
- rst_rasPtr_o = ckptRasPtr+1 if isCall; ckptRasPtr-1 if isRet; otherwise ckptRasPtr.
- Pointer arithmetic wraps modulo 2^RAS_PTR_W.
REQ-017 Update values SHALL be: upd_pc_o = erroVAddr, upd_take_o = corrTake, upd_ghr_o = ckptGhr (the unshifted checkpoint).
REQ-018 mis_cnt_o SHALL increment by 1 on each accept and saturate at 16'hFFFF.
REQ-019 Exception handling: exc_flush_i=1 in any state SHALL force IDLE on the next edge.
- The pending redirect, restore and update are dropped.
- rdr_valid_o, rst_valid_o and upd_valid_o are combinationally 0 in that cycle.
- mis_cnt_o is unaffected.
REQ-020 If exc_flush_i and amd_flush_i are both 1 in the same cycle, the amend request SHALL be discarded and the counter SHALL NOT increment.
REQ-021 An amd_flush_i that arrives while not in IDLE SHALL be ignored; the producer holds it until amd_ready_o=1.
REQ-022 rdr_ready_i SHALL be ignored outside REDIR.
REQ-023 The restore port and update port SHALL only toggle in RESTORE and SHALL be 0 elsewhere.
REQ-024 Latency: accept at cycle N gives rdr_valid_o at N+1.
- With rdr_ready_i=1 at N+1, rst_valid_o and upd_valid_o occur at N+2.
- amd_ready_o=1 again at N+3.

Reset
REQ-025 When rst=0 at a clock edge, the block SHALL reset:
- FSM to IDLE.
- All latched fields to 0.
- mis_cnt_o to 0.
REQ-026 While rst=0, amd_ready_o=0 and all valid outputs SHALL be 0.
REQ-027 Reset SHALL win over every other input, including mid-REDIR; no redirect is issued after reset releases.

Verification
REQ-028 Taken mispredict: erroVAddr=0x80001000, corrDest=0x80002000, take=1, rdr_ready_i=1.
- Next cycle: rdr_pc_o=0x80002000.
- Following cycle: rst_valid_o=1, mis_cnt_o=1.
REQ-029 Not-taken mispredict with fetch stall: erroVAddr=0xFFFFFFFC, take=0, rdr_ready_i=0 for 3 cycles.
- rdr_pc_o=0x00000004, held stable for 4 cycles.
- Restore occurs after the handshake.
REQ-030 RAS repair:
- isCall, ckptRasPtr=7 -> rst_rasPtr_o=0.
- isRet, ckptRasPtr=0 -> rst_rasPtr_o=7.
- GHR 0xA5, take=1 -> rst_ghr_o=0x4B.
REQ-031 Exception preemption:
- exc_flush_i pulses while in REDIR -> rdr_valid_o drops that cycle, no restore follows, state returns to IDLE.
- Simultaneous exc and amend -> no accept, counter unchanged.
REQ-032 Busy and saturation:
- A second amd_flush_i held during REDIR is accepted only at IDLE.
- 65536 accepts leave mis_cnt_o=0xFFFF.
